// File: rtl/image_loader_if.sv
// Pixel-beat handshake between the input pins and the image loader.
interface image_loader_if #(
  parameter int unsigned WORD = 8
) ();
  logic [WORD-1:0] data_in;
  logic            data_valid;
  logic            data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/image_loader.sv
// Collects binarized image beats into a flat pixel register while the sequencer is in load,
// then pulses load_done and holds the image for layer 1 until the next load begins.
module image_loader #(
  parameter int unsigned IMG_W = 28,
  parameter int unsigned IMG_H = 28,
  parameter int unsigned WORD  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             state,
  image_loader_if.slave          bus,
  output logic                   load_done,
  output logic                   image_valid,
  output logic [IMG_W*IMG_H-1:0] pixels
);

  localparam int unsigned NPIX  = IMG_W * IMG_H;
  localparam int unsigned BEATS = NPIX / WORD;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [2:0]  ST_LOAD = 3'b001;

  typedef enum logic [1:0] {L_WAIT, L_FILL, L_DONE} lstate_t;

  lstate_t          ls_q, ls_d;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q;
  logic             start_c, abort_c, accept_c, last_c;
  logic             in_load_c;

  assign in_load_c      = (state == ST_LOAD);
  assign bus.data_ready = ready_q;

  // Loader state register
  always_ff @(posedge clk) begin
    if (rst) ls_q <= L_WAIT;
    else     ls_q <= ls_d;
  end

  // Next-state and per-cycle control decode; abort wins over a same-cycle beat
  always_comb begin
    ls_d     = ls_q;
    start_c  = 1'b0;
    abort_c  = 1'b0;
    accept_c = 1'b0;
    last_c   = 1'b0;
    unique case (ls_q)
      L_WAIT: begin
        if (in_load_c) begin
          ls_d    = L_FILL;
          start_c = 1'b1;
        end
      end
      L_FILL: begin
        if (!in_load_c) begin
          ls_d    = L_WAIT;
          abort_c = 1'b1;
        end else if (bus.data_valid) begin
          accept_c = 1'b1;
          if (cnt_q == CNT_W'(BEATS - 1)) begin
            ls_d   = L_DONE;
            last_c = 1'b1;
          end
        end
      end
      L_DONE: begin
        if (!in_load_c) ls_d = L_WAIT;
      end
      default: ls_d = L_WAIT;
    endcase
  end

  // Beat counter, pixel register and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      load_done   <= 1'b0;
      image_valid <= 1'b0;
      pixels      <= '0;
    end else begin
      ready_q   <= (ls_d == L_FILL);
      load_done <= last_c;
      if (start_c || abort_c) cnt_q <= '0;
      if (start_c) image_valid <= 1'b0;
      if (accept_c) begin
        pixels[32'(cnt_q) * WORD +: WORD] <= bus.data_in;
        cnt_q <= last_c ? '0 : cnt_q + CNT_W'(1);
      end
      if (last_c) image_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader: full loads, gapped loads, overflow, abort, mid-load reset, hold.
module tb_image_loader;

  localparam int unsigned NPIX  = 784;
  localparam int unsigned BEATS = 98;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      state;
  logic            load_done;
  logic            image_valid;
  logic [NPIX-1:0] pixels;

  image_loader_if #(.WORD(8)) bus ();

  image_loader dut (
    .clk        (clk),
    .rst        (rst),
    .state      (state),
    .bus        (bus.slave),
    .load_done  (load_done),
    .image_valid(image_valid),
    .pixels     (pixels)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc_used = 0;
  logic [NPIX-1:0] ramp_img;
  logic [NPIX-1:0] exp_pix;

  task automatic chk(input string tag, input logic [NPIX-1:0] obs, input logic [NPIX-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] beat_val(input int kind, input int k);
    case (kind)
      0:       return 8'(k);
      1:       return 8'hAA;
      2:       return 8'h55;
      default: return 8'hFF;
    endcase
  endfunction

  // Offers n beats (optionally every other cycle) and checks beat count, done pulse and image
  task automatic feed(input int n, input int kind, input bit gap, input bit expect_done,
                      input string tag);
    int   acc = 0;
    int   cyc = 0;
    int   pulses = 0;
    int   ready_low = 0;
    while (acc < n && cyc < 400) begin
      bus.data_valid = gap ? ((cyc % 2) == 0) : 1'b1;
      bus.data_in    = beat_val(kind, acc);
      if (bus.data_valid && !bus.data_ready) ready_low++;
      @(negedge clk);
      cyc++;
      if (bus.data_valid) begin
        exp_pix[acc*8 +: 8] = bus.data_in;
        acc++;
      end
      if (load_done) pulses++;
    end
    bus.data_valid = 1'b0;
    cyc_used = cyc;
    chk({tag, "_beats"},     NPIX'(acc),       NPIX'(n));
    chk({tag, "_ready_low"}, NPIX'(ready_low), NPIX'(0));
    chk({tag, "_pulses"},    NPIX'(pulses),    NPIX'(expect_done ? 1 : 0));
    chk({tag, "_done_now"},  NPIX'(load_done), NPIX'(expect_done));
    chk({tag, "_pixels"},    pixels,           exp_pix);
  endtask

  initial begin
    rst = 1'b1;
    state = 3'b000;
    bus.data_valid = 1'b0;
    bus.data_in = 8'h00;
    exp_pix = '0;
    for (int k = 0; k < int'(BEATS); k++) ramp_img[k*8 +: 8] = 8'(k);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_pixels", pixels, '0);
    chk("rst_done",   NPIX'(load_done), NPIX'(0));
    chk("rst_valid",  NPIX'(image_valid), NPIX'(0));
    chk("rst_ready",  NPIX'(bus.data_ready), NPIX'(0));

    // Back-to-back ramp load
    rst = 1'b0;
    state = 3'b001;
    @(negedge clk);
    chk("s1_ready_rise", NPIX'(bus.data_ready), NPIX'(1));
    feed(98, 0, 1'b0, 1'b1, "s1");
    chk("s1_latency", NPIX'(cyc_used), NPIX'(98));
    chk("s1_byte0",   NPIX'(pixels[7:0]),     NPIX'(8'h00));
    chk("s1_byte1",   NPIX'(pixels[15:8]),    NPIX'(8'h01));
    chk("s1_byte97",  NPIX'(pixels[783:776]), NPIX'(8'h61));
    chk("s1_valid",   NPIX'(image_valid), NPIX'(1));

    // Overflow: load still requested after done, beats must be ignored
    for (int i = 0; i < 5; i++) begin
      bus.data_valid = 1'b1;
      bus.data_in = 8'hFF;
      @(negedge clk);
      chk("ovf_ready", NPIX'(bus.data_ready), NPIX'(0));
      chk("ovf_done",  NPIX'(load_done), NPIX'(0));
    end
    bus.data_valid = 1'b0;
    chk("ovf_pixels", pixels, ramp_img);
    chk("ovf_valid",  NPIX'(image_valid), NPIX'(1));

    // Gapped load of the same image
    state = 3'b000;
    @(negedge clk);
    chk("s2_hold_valid", NPIX'(image_valid), NPIX'(1));
    state = 3'b001;
    @(negedge clk);
    chk("s2_ready",       NPIX'(bus.data_ready), NPIX'(1));
    chk("s2_valid_clear", NPIX'(image_valid), NPIX'(0));
    feed(98, 0, 1'b1, 1'b1, "s2");
    chk("s2_latency", NPIX'(cyc_used), NPIX'(195));
    chk("s2_image",   pixels, ramp_img);

    // Partial load then abort, with a beat offered on the abort edge
    state = 3'b000;
    @(negedge clk);
    state = 3'b001;
    @(negedge clk);
    feed(40, 1, 1'b0, 1'b0, "s3a");
    state = 3'b000;
    bus.data_valid = 1'b1;
    bus.data_in = 8'h00;
    @(negedge clk);
    bus.data_valid = 1'b0;
    chk("ab_ready", NPIX'(bus.data_ready), NPIX'(0));
    chk("ab_done",  NPIX'(load_done), NPIX'(0));
    chk("ab_valid", NPIX'(image_valid), NPIX'(0));
    chk("ab_head",  NPIX'(pixels[319:0]), NPIX'({40{8'hAA}}));
    chk("ab_tail",  NPIX'(pixels[783:320]), NPIX'(ramp_img[783:320]));
    chk("ab_byte40_kept", NPIX'(pixels[327:320]), NPIX'(8'h28));

    // Reload with alternating pattern
    state = 3'b001;
    @(negedge clk);
    feed(98, 2, 1'b0, 1'b1, "s3b");
    chk("s3b_image", pixels, NPIX'({98{8'h55}}));
    chk("s3b_bit0",  NPIX'(pixels[0]), NPIX'(1));
    @(negedge clk);
    chk("s3b_single_pulse", NPIX'(load_done), NPIX'(0));

    // Reset in the middle of a load, load still requested
    state = 3'b000;
    @(negedge clk);
    state = 3'b001;
    @(negedge clk);
    feed(60, 0, 1'b0, 1'b0, "s4a");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_pix = '0;
    chk("s4_rst_pixels", pixels, '0);
    chk("s4_rst_done",   NPIX'(load_done), NPIX'(0));
    chk("s4_rst_valid",  NPIX'(image_valid), NPIX'(0));
    chk("s4_rst_ready",  NPIX'(bus.data_ready), NPIX'(0));
    @(negedge clk);
    chk("s4_ready", NPIX'(bus.data_ready), NPIX'(1));
    feed(98, 0, 1'b0, 1'b1, "s4b");
    chk("s4_image", pixels, ramp_img);

    // Sequencer walks through the layers and idle; image stays valid
    state = 3'b010;
    @(negedge clk);
    chk("ch_l1_valid", NPIX'(image_valid), NPIX'(1));
    chk("ch_l1_ready", NPIX'(bus.data_ready), NPIX'(0));
    chk("ch_l1_done",  NPIX'(load_done), NPIX'(0));
    state = 3'b011;
    @(negedge clk);
    state = 3'b100;
    @(negedge clk);
    state = 3'b000;
    @(negedge clk);
    chk("ch_idle_valid", NPIX'(image_valid), NPIX'(1));
    state = 3'b101;
    @(negedge clk);
    chk("ch_unk_ready", NPIX'(bus.data_ready), NPIX'(0));
    chk("ch_unk_valid", NPIX'(image_valid), NPIX'(1));
    chk("ch_unk_image", pixels, ramp_img);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
